compute_t: RTL and testbench

Downstream of the Sp-packing stage. Once the 64 packed S' coefficients sit in the Sp RAM, this block computes the first IDCT product T = S' × C. S' and C are both 8×8. Each result is arithmetically shifted and written, row-major, into the T RAM for the second matrix stage. A `start` pulse, driven by the packer's `finish`, triggers one 8×8 block; `finish` pulses when all 64 T words are written.

---
 rtl/compute_t_if.sv | 34 +++
 rtl/compute_t.sv | 166 ++++++++++++++++
 tb/tb_compute_t.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/compute_t_if.sv
// Bus bundle for compute_t: start/busy/finish handshake plus the Sp, C and T RAM ports.
// master = compute_t side, slave = RAM/sequencer side.
interface compute_t_if;
  logic        start;
  logic        busy;
  logic        finish;

  logic [6:0]  DP_RAM_address_Sp_b;
  logic [31:0] DP_RAM_read_data_Sp_b;
  logic        DP_RAM_we_Sp_b;

  logic [6:0]  DP_RAM_address_C_a;
  logic [6:0]  DP_RAM_address_C_b;
  logic [31:0] DP_RAM_read_data_C_a;
  logic [31:0] DP_RAM_read_data_C_b;

  logic [6:0]  DP_RAM_address_T_a;
  logic [31:0] DP_RAM_write_data_T_a;
  logic        DP_RAM_we_T_a;

  modport master (
    input  start, DP_RAM_read_data_Sp_b, DP_RAM_read_data_C_a, DP_RAM_read_data_C_b,
    output busy, finish, DP_RAM_address_Sp_b, DP_RAM_we_Sp_b,
           DP_RAM_address_C_a, DP_RAM_address_C_b,
           DP_RAM_address_T_a, DP_RAM_write_data_T_a, DP_RAM_we_T_a
  );

  modport slave (
    output start, DP_RAM_read_data_Sp_b, DP_RAM_read_data_C_a, DP_RAM_read_data_C_b,
    input  busy, finish, DP_RAM_address_Sp_b, DP_RAM_we_Sp_b,
           DP_RAM_address_C_a, DP_RAM_address_C_b,
           DP_RAM_address_T_a, DP_RAM_write_data_T_a, DP_RAM_we_T_a
  );
endinterface

// File: rtl/compute_t.sv
// First IDCT matrix product T = S' x C, one 8x8 block per start pulse, T written row-major.
// Define CLIP_T_EN to saturate each shifted result to 16-bit signed before writing.
module compute_t #(
  parameter int SHIFT = 8
) (
  input  logic        Clock_50,
  input  logic        Resetn,
  compute_t_if.master bus
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD_S, S_MAC, S_WRITE, S_DONE} state_t;

  state_t      r_state, w_state_next;
  logic [5:0]  r_cnt, w_cnt_next;
  logic [2:0]  r_row, w_row_next;
  logic        w_issue_s, w_issue_c;

  // Read pipeline: stage 0 = address registered, stage 1 = RAM data arriving next edge.
  logic        r_s_v0, r_s_v1, r_c_v0, r_c_v1;
  logic [1:0]  r_s_idx0, r_s_idx1, r_p0, r_p1;
  logic [2:0]  r_j0, r_j1;

  logic [6:0]  r_sp_addr, r_c_addr_a, r_c_addr_b, r_t_addr;
  logic [31:0] r_t_data;
  logic        r_t_we;
  logic signed [15:0] r_s [8];
  logic signed [34:0] r_acc;

  logic signed [15:0] w_sel_a, w_sel_b, w_c_a, w_c_b;
  logic signed [31:0] w_prod_a, w_prod_b;
  logic signed [34:0] w_acc_base, w_acc_next, w_shifted;
  logic [31:0]        w_t_result;
  logic               w_unused_bits;

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge Clock_50 or negedge Resetn) begin
    if (!Resetn) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_row   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_row   <= w_row_next;
    end
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_row_next   = r_row;
    w_issue_s    = 1'b0;
    w_issue_c    = 1'b0;
    case (r_state)
      S_IDLE: if (bus.start) begin
        w_state_next = S_LOAD_S;
        w_cnt_next   = '0;
        w_row_next   = '0;
      end
      S_LOAD_S: begin
        w_issue_s = 1'b1;
        if (r_cnt == 6'd3) begin
          w_state_next = S_MAC;
          w_cnt_next   = '0;
        end else w_cnt_next = r_cnt + 6'd1;
      end
      S_MAC: begin
        w_issue_c = 1'b1;
        if (r_cnt == 6'd31) begin
          w_state_next = S_WRITE;
          w_cnt_next   = '0;
        end else w_cnt_next = r_cnt + 6'd1;
      end
      // Drain: the row's last accumulate and T write land here before S is reloaded.
      S_WRITE: begin
        if (r_cnt == 6'd2) begin
          w_cnt_next = '0;
          if (r_row == 3'd7) w_state_next = S_DONE;
          else begin
            w_state_next = S_LOAD_S;
            w_row_next   = r_row + 3'd1;
          end
        end else w_cnt_next = r_cnt + 6'd1;
      end
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  assign w_c_a      = bus.DP_RAM_read_data_C_a[15:0];
  assign w_c_b      = bus.DP_RAM_read_data_C_b[15:0];
  assign w_sel_a    = r_s[{r_p1, 1'b0}];
  assign w_sel_b    = r_s[{r_p1, 1'b1}];
  assign w_prod_a   = w_sel_a * w_c_a;
  assign w_prod_b   = w_sel_b * w_c_b;
  assign w_acc_base = (r_p1 == 2'd0) ? '0 : r_acc;
  assign w_acc_next = w_acc_base + {{3{w_prod_a[31]}}, w_prod_a} + {{3{w_prod_b[31]}}, w_prod_b};
  assign w_shifted  = w_acc_next >>> SHIFT;

`ifdef CLIP_T_EN
  always_comb begin
    if (w_shifted > 35'sd32767)       w_t_result = 32'h0000_7FFF;
    else if (w_shifted < -35'sd32768) w_t_result = 32'hFFFF_8000;
    else                              w_t_result = {{16{w_shifted[15]}}, w_shifted[15:0]};
  end
`else
  assign w_t_result = w_shifted[31:0];
`endif

  assign w_unused_bits = ^{bus.DP_RAM_read_data_C_a[31:16], bus.DP_RAM_read_data_C_b[31:16],
                           w_shifted[34:32]};

  // NOTE: the eight S registers are plain flops, so they reset with the rest of the datapath.
  always_ff @(posedge Clock_50 or negedge Resetn) begin
    if (!Resetn) begin
      r_s_v0 <= 1'b0;  r_s_v1 <= 1'b0;  r_c_v0 <= 1'b0;  r_c_v1 <= 1'b0;
      r_s_idx0 <= '0;  r_s_idx1 <= '0;  r_p0 <= '0;  r_p1 <= '0;
      r_j0 <= '0;      r_j1 <= '0;
      r_sp_addr <= '0; r_c_addr_a <= '0; r_c_addr_b <= '0; r_t_addr <= '0;
      r_t_data  <= '0; r_t_we <= 1'b0;   r_acc <= '0;
      for (int n = 0; n < 8; n++) r_s[n] <= '0;
    end else begin
      r_s_v0   <= w_issue_s;
      r_s_idx0 <= r_cnt[1:0];
      r_c_v0   <= w_issue_c;
      r_p0     <= r_cnt[1:0];
      r_j0     <= r_cnt[4:2];
      r_s_v1   <= r_s_v0;
      r_s_idx1 <= r_s_idx0;
      r_c_v1   <= r_c_v0;
      r_p1     <= r_p0;
      r_j1     <= r_j0;
      if (w_issue_s) r_sp_addr <= {2'b00, r_row, r_cnt[1:0]};
      // C[k][j] at k*8+j: even k = 2p on port a, odd k = 2p+1 on port b.
      if (w_issue_c) begin
        r_c_addr_a <= {1'b0, r_cnt[1:0], 1'b0, r_cnt[4:2]};
        r_c_addr_b <= {1'b0, r_cnt[1:0], 1'b1, r_cnt[4:2]};
      end
      if (r_s_v1) begin
        r_s[{r_s_idx1, 1'b0}] <= bus.DP_RAM_read_data_Sp_b[31:16];
        r_s[{r_s_idx1, 1'b1}] <= bus.DP_RAM_read_data_Sp_b[15:0];
      end
      r_t_we <= 1'b0;
      if (r_c_v1) begin
        r_acc <= w_acc_next;
        if (r_p1 == 2'd3) begin
          r_t_we   <= 1'b1;
          r_t_addr <= {1'b0, r_row, r_j1};
          r_t_data <= w_t_result;
        end
      end
    end
  end

  assign bus.DP_RAM_address_Sp_b   = r_sp_addr;
  assign bus.DP_RAM_we_Sp_b        = 1'b0;
  assign bus.DP_RAM_address_C_a    = r_c_addr_a;
  assign bus.DP_RAM_address_C_b    = r_c_addr_b;
  assign bus.DP_RAM_address_T_a    = r_t_addr;
  assign bus.DP_RAM_write_data_T_a = r_t_data;
  assign bus.DP_RAM_we_T_a         = r_t_we;
  assign bus.busy                  = (r_state != S_IDLE) && (r_state != S_DONE);
  assign bus.finish                = (r_state == S_DONE);

endmodule

// File: tb/tb_compute_t.sv
// Testbench for compute_t: RAM models for Sp/C, T capture, and a plain-arithmetic matrix model.
// Build with +define+CLIP_T_EN to check the saturating variant.
module tb_compute_t;
  localparam int SHIFT = 8;

  logic Clock_50;
  logic Resetn;
  compute_t_if bus ();

  compute_t #(.SHIFT(SHIFT)) dut (
    .Clock_50 (Clock_50),
    .Resetn   (Resetn),
    .bus      (bus)
  );

  initial Clock_50 = 1'b0;
  always #5 Clock_50 = ~Clock_50;

  logic [31:0] sp_mem [32];
  logic [31:0] c_mem  [64];
  logic [31:0] t_got  [64];

  // One-cycle registered-read RAMs: address from edge N is seen by the DUT at edge N+2.
  always @(posedge Clock_50) begin
    bus.DP_RAM_read_data_Sp_b <= sp_mem[bus.DP_RAM_address_Sp_b[4:0]];
    bus.DP_RAM_read_data_C_a  <= c_mem[bus.DP_RAM_address_C_a[5:0]];
    bus.DP_RAM_read_data_C_b  <= c_mem[bus.DP_RAM_address_C_b[5:0]];
  end

  int checks = 0;
  int failures = 0;
  int wr_cnt, fin_cnt, order_err, overlap_err, busy_err, cyc_to_fin;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [31:0] model_t(input int i, input int j);
    longint acc;
    logic [31:0] w;
    logic signed [15:0] s, c;
    acc = 0;
    for (int k = 0; k < 8; k++) begin
      w = sp_mem[4*i + k/2];
      s = (k % 2 == 0) ? w[31:16] : w[15:0];
      w = c_mem[8*k + j];
      c = w[15:0];
      acc += longint'(s) * longint'(c);
    end
    acc = acc >>> SHIFT;
`ifdef CLIP_T_EN
    if (acc > 32767) acc = 32767;
    else if (acc < -32768) acc = -32768;
`endif
    return acc[31:0];
  endfunction

  task automatic capture();
    if (bus.DP_RAM_we_T_a) begin
      if (bus.DP_RAM_address_T_a != 7'(wr_cnt)) order_err++;
      t_got[bus.DP_RAM_address_T_a[5:0]] = bus.DP_RAM_write_data_T_a;
      wr_cnt++;
    end
    if (bus.finish) begin
      fin_cnt++;
      if (bus.DP_RAM_we_T_a) overlap_err++;
      if (bus.busy) busy_err++;
    end
  endtask

  task automatic clear_capture();
    for (int n = 0; n < 64; n++) t_got[n] = 32'hDEAD_BEEF;
    wr_cnt = 0; fin_cnt = 0; order_err = 0; overlap_err = 0; busy_err = 0; cyc_to_fin = 0;
  endtask

  task automatic pulse_start();
    @(negedge Clock_50);
    check("busy_before_start", bus.busy, 1'b0);
    bus.start = 1'b1;
    @(negedge Clock_50);
    bus.start = 1'b0;
    check("busy_rise", bus.busy, 1'b1);
  endtask

  // Runs one block; repulse_at > 0 re-asserts start for one cycle at that cycle count.
  task automatic run_block(input string name, input int repulse_at);
    int cyc;
    bit done;
    clear_capture();
    pulse_start();
    cyc = 1;
    done = 1'b0;
    while (!done && cyc < 450) begin
      @(negedge Clock_50);
      cyc++;
      bus.start = (cyc == repulse_at);
      if (!bus.finish && !bus.busy) busy_err++;
      capture();
      if (bus.finish) begin
        done = 1'b1;
        cyc_to_fin = cyc;
      end
    end
    bus.start = 1'b0;
    check({name, "_finish_seen"}, done, 1'b1);
    check({name, "_finish_latency_ok"}, (cyc_to_fin <= 400), 1'b1);
    repeat (8) begin
      @(negedge Clock_50);
      capture();
    end
    check({name, "_write_count"}, wr_cnt, 64);
    check({name, "_finish_count"}, fin_cnt, 1);
    check({name, "_addr_order_errs"}, order_err, 0);
    check({name, "_we_during_finish"}, overlap_err, 0);
    check({name, "_busy_errs"}, busy_err, 0);
    check({name, "_busy_idle"}, bus.busy, 1'b0);
    for (int n = 0; n < 64; n++)
      check($sformatf("%s_T[%0d]", name, n), t_got[n], model_t(n / 8, n % 8));
  endtask

  task automatic fill_zero();
    for (int n = 0; n < 32; n++) sp_mem[n] = 32'h0;
    for (int n = 0; n < 64; n++) c_mem[n] = 32'h0;
  endtask

  task automatic fill_random();
    for (int n = 0; n < 32; n++) sp_mem[n] = $urandom;
    for (int n = 0; n < 64; n++) c_mem[n] = $urandom;
  endtask

  task automatic fill_test2();
    fill_zero();
    sp_mem[0] = 32'h0100_0000;
    for (int n = 0; n < 64; n++) c_mem[n] = {$urandom_range(65535, 0), 16'h0000};
    for (int j = 0; j < 8; j++) c_mem[j] = 32'(j + 1);
  endtask

  task automatic check_test2(input string name);
    for (int j = 0; j < 8; j++) check($sformatf("%s_row0_j%0d", name, j), t_got[j], 32'(j + 1));
    check({name, "_T[9]_zero"}, t_got[9], 32'h0);
  endtask

  initial begin
    Resetn = 1'b0;
    bus.start = 1'b0;
    fill_zero();
    clear_capture();
    repeat (3) @(negedge Clock_50);
    check("rst_addr_sp", bus.DP_RAM_address_Sp_b, 7'h0);
    check("rst_addr_c_a", bus.DP_RAM_address_C_a, 7'h0);
    check("rst_addr_c_b", bus.DP_RAM_address_C_b, 7'h0);
    check("rst_addr_t", bus.DP_RAM_address_T_a, 7'h0);
    check("rst_wdata_t", bus.DP_RAM_write_data_T_a, 32'h0);
    check("rst_we_t", bus.DP_RAM_we_T_a, 1'b0);
    check("rst_we_sp", bus.DP_RAM_we_Sp_b, 1'b0);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_finish", bus.finish, 1'b0);
    Resetn = 1'b1;
    repeat (2) @(negedge Clock_50);

    // Sp all zero, C arbitrary
    fill_zero();
    for (int n = 0; n < 64; n++) c_mem[n] = $urandom;
    run_block("zero_s", 0);
    check("zero_s_T[63]", t_got[63], 32'h0);

    fill_test2();
    run_block("single", 0);
    check_test2("single");

    // Row 0 all -256, C all 1
    fill_zero();
    for (int n = 0; n < 4; n++) sp_mem[n] = 32'hFF00_FF00;
    for (int n = 0; n < 64; n++) c_mem[n] = 32'h0000_0001;
    run_block("neg_row", 0);
    for (int j = 0; j < 8; j++) check($sformatf("neg_row_j%0d", j), t_got[j], 32'hFFFF_FFF8);
    check("neg_row_T[8]", t_got[8], 32'h0);

    // Full-scale positive
    for (int n = 0; n < 32; n++) sp_mem[n] = 32'h7FFF_7FFF;
    for (int n = 0; n < 64; n++) c_mem[n] = 32'h0000_7FFF;
    run_block("max", 0);
`ifdef CLIP_T_EN
    check("max_T[0]", t_got[0], 32'h0000_7FFF);
    check("max_T[63]", t_got[63], 32'h0000_7FFF);
`else
    check("max_T[0]", t_got[0], 32'h01FF_F800);
    check("max_T[63]", t_got[63], 32'h01FF_F800);
`endif

    fill_random();
    run_block("rand0", 0);
    fill_random();
    run_block("rand1", 0);

    // start re-pulsed mid-block must be ignored
    fill_random();
    run_block("repulse", 50);

    // Reset mid-block at cycle 100: no writes, no finish, then a clean block
    fill_test2();
    clear_capture();
    pulse_start();
    for (int c = 2; c <= 100; c++) @(negedge Clock_50);
    Resetn = 1'b0;
    #1;
    check("abort_we_t", bus.DP_RAM_we_T_a, 1'b0);
    check("abort_busy", bus.busy, 1'b0);
    check("abort_addr_t", bus.DP_RAM_address_T_a, 7'h0);
    fin_cnt = 0;
    repeat (5) begin
      @(negedge Clock_50);
      capture();
    end
    Resetn = 1'b1;
    repeat (10) begin
      @(negedge Clock_50);
      capture();
    end
    check("abort_no_finish", fin_cnt, 0);
    run_block("after_abort", 0);
    check_test2("after_abort");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
